mem_issue_queue: RTL and testbench



---
 rtl/mem_issue_queue_pkg.sv | 48 ++++
 rtl/mem_iq_entry.sv | 81 ++++++++
 rtl/mem_issue_queue.sv | 125 ++++++++++++
 tb/tb_mem_issue_queue.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_issue_queue_pkg.sv
// mem_issue_queue_pkg
//   Shared types for the memory issue queue: the queue entry payload
//   (MemIqEntrySt), the issued-op record (MemExeSt), the memory op class
//   encodings and the default queue depth.
package mem_issue_queue_pkg;

    localparam int unsigned MEM_IQ_DEPTH = 8;
    localparam int unsigned MEM_PREG_W   = 6;
    localparam int unsigned MEM_ROB_W    = 6;

    typedef enum logic [1:0] {
        MEM_LOAD  = 2'd0,
        MEM_STORE = 2'd1,
        MEM_CACOP = 2'd2
    } mem_oc_e;

    typedef struct packed {
        logic [MEM_PREG_W-1:0] psrc0;
        logic [MEM_PREG_W-1:0] psrc1;
        logic                  src0_ready;
        logic                  src1_ready;
        logic [31:0]           imm;
        mem_oc_e               mem_oc;
        logic [3:0]            code;
        logic [MEM_PREG_W-1:0] pdest;
        logic                  pdest_valid;
        logic [MEM_ROB_W-1:0]  rob_idx;
        logic                  llbit;
    } MemIqEntrySt;

    typedef struct packed {
        logic                  valid;
        logic [MEM_ROB_W-1:0]  rob_idx;
        logic [MEM_PREG_W-1:0] pdest;
        logic                  pdest_valid;
    } MemExeBaseSt;

    typedef struct packed {
        MemExeBaseSt base;
        mem_oc_e     mem_oc;
        logic [3:0]  code;
        logic [31:0] imm;
        logic [31:0] src0;
        logic [31:0] src1;
        logic        llbit;
    } MemExeSt;

endpackage

// File: rtl/mem_iq_entry.sv
// mem_iq_entry
//   One issue-queue slot: payload, valid bit and two source-ready bits that
//   are set by matching wakeup broadcasts.
//   clk/rst/flush_i  : clock, sync active-high reset, sync flush
//   write_i, data_i  : load the slot from dispatch
//   clear_i          : slot issued, drop valid
//   wakeup_*_i       : result broadcast ports
//   valid_o, entry_o : current slot state
module mem_iq_entry
    import mem_issue_queue_pkg::*;
#(
    parameter int unsigned WAKEUP_PORTS = 4,
    parameter int unsigned PREG_W       = MEM_PREG_W
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 flush_i,
    input  logic                                 write_i,
    input  logic                                 clear_i,
    input  MemIqEntrySt                          data_i,
    input  logic [WAKEUP_PORTS-1:0]              wakeup_valid_i,
    input  logic [WAKEUP_PORTS-1:0][PREG_W-1:0]  wakeup_preg_i,
    output logic                                 valid_o,
    output MemIqEntrySt                          entry_o
);

    logic        valid_q, valid_d;
    MemIqEntrySt ent_q, ent_d;

    function automatic logic woken(
        input logic [MEM_PREG_W-1:0]                psrc,
        input logic [WAKEUP_PORTS-1:0]              wv,
        input logic [WAKEUP_PORTS-1:0][PREG_W-1:0]  wp
    );
        logic hit;
        hit = 1'b0;
        for (int unsigned p = 0; p < WAKEUP_PORTS; p++) begin
            if (wv[p] && (wp[p] == PREG_W'(psrc))) hit = 1'b1;
        end
        return hit;
    endfunction

    always_comb begin
        valid_d = valid_q;
        ent_d   = ent_q;
        if (write_i) begin
            // psrc 0 is the hardwired zero register, never waited on
            valid_d          = 1'b1;
            ent_d            = data_i;
            ent_d.src0_ready = data_i.src0_ready || (data_i.psrc0 == '0) ||
                               woken(data_i.psrc0, wakeup_valid_i, wakeup_preg_i);
            ent_d.src1_ready = data_i.src1_ready || (data_i.psrc1 == '0) ||
                               woken(data_i.psrc1, wakeup_valid_i, wakeup_preg_i);
        end else if (valid_q) begin
            if (clear_i) begin
                valid_d          = 1'b0;
                ent_d.src0_ready = 1'b0;
                ent_d.src1_ready = 1'b0;
            end else begin
                ent_d.src0_ready = ent_q.src0_ready ||
                                   woken(ent_q.psrc0, wakeup_valid_i, wakeup_preg_i);
                ent_d.src1_ready = ent_q.src1_ready ||
                                   woken(ent_q.psrc1, wakeup_valid_i, wakeup_preg_i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            valid_q <= 1'b0;
            ent_q   <= '0;
        end else begin
            valid_q <= valid_d;
            ent_q   <= ent_d;
        end
    end

    assign valid_o = valid_q;
    assign entry_o = ent_q;

endmodule

// File: rtl/mem_issue_queue.sv
// mem_issue_queue
//   In-order issue queue for load/store/cacop micro-ops. Entries wait in
//   program order until both sources are woken; the oldest one reads the
//   register file and is launched through a single output register.
//   clk, rst, flush_i          : clock, sync active-high reset, sync flush
//   dis_valid_i/dis_ready_o/dis_i : dispatch handshake and entry payload
//   wakeup_valid_i/wakeup_preg_i  : result broadcast ports
//   rf_raddr*_o / rf_rdata*_i     : head-entry register file read
//   exe_o / exe_ready_i           : issued op and downstream accept
module mem_issue_queue
    import mem_issue_queue_pkg::*;
#(
    parameter int unsigned DEPTH        = MEM_IQ_DEPTH,
    parameter int unsigned WAKEUP_PORTS = 4,
    parameter int unsigned PREG_W       = MEM_PREG_W
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 flush_i,
    input  logic                                 dis_valid_i,
    output logic                                 dis_ready_o,
    input  MemIqEntrySt                          dis_i,
    input  logic [WAKEUP_PORTS-1:0]              wakeup_valid_i,
    input  logic [WAKEUP_PORTS-1:0][PREG_W-1:0]  wakeup_preg_i,
    output logic [PREG_W-1:0]                    rf_raddr0_o,
    output logic [PREG_W-1:0]                    rf_raddr1_o,
    input  logic [31:0]                          rf_rdata0_i,
    input  logic [31:0]                          rf_rdata1_i,
    output MemExeSt                              exe_o,
    input  logic                                 exe_ready_i
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    MemExeSt          exe_q, exe_d;

    MemIqEntrySt      ent [DEPTH];
    logic [DEPTH-1:0] ent_valid, ent_write, ent_clear;

    logic [IDX_W-1:0] head_idx, tail_idx;
    logic             empty, full, dis_fire, issue_fire;
    MemIqEntrySt      head_ent;

    assign head_idx = head_q[IDX_W-1:0];
    assign tail_idx = tail_q[IDX_W-1:0];
    assign empty    = (head_q == tail_q);
    assign full     = (head_idx == tail_idx) && (head_q[IDX_W] != tail_q[IDX_W]);

    assign dis_ready_o = ~full;
    assign dis_fire    = dis_valid_i && !full;

    assign head_ent    = ent[head_idx];
    assign rf_raddr0_o = PREG_W'(head_ent.psrc0);
    assign rf_raddr1_o = PREG_W'(head_ent.psrc1);

    assign issue_fire = !empty && ent_valid[head_idx] &&
                        head_ent.src0_ready && head_ent.src1_ready &&
                        (!exe_q.base.valid || exe_ready_i);

    always_comb begin
        ent_write = '0;
        ent_clear = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            ent_write[i] = dis_fire   && (tail_idx == IDX_W'(i));
            ent_clear[i] = issue_fire && (head_idx == IDX_W'(i));
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        mem_iq_entry #(
            .WAKEUP_PORTS (WAKEUP_PORTS),
            .PREG_W       (PREG_W)
        ) u_ent (
            .clk            (clk),
            .rst            (rst),
            .flush_i        (flush_i),
            .write_i        (ent_write[g]),
            .clear_i        (ent_clear[g]),
            .data_i         (dis_i),
            .wakeup_valid_i (wakeup_valid_i),
            .wakeup_preg_i  (wakeup_preg_i),
            .valid_o        (ent_valid[g]),
            .entry_o        (ent[g])
        );
    end

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        exe_d  = exe_q;
        if (dis_fire)   tail_d = tail_q + 1'b1;
        if (issue_fire) begin
            head_d                = head_q + 1'b1;
            exe_d.base.valid      = 1'b1;
            exe_d.base.rob_idx    = head_ent.rob_idx;
            exe_d.base.pdest      = head_ent.pdest;
            exe_d.base.pdest_valid= head_ent.pdest_valid;
            exe_d.mem_oc          = head_ent.mem_oc;
            exe_d.code            = head_ent.code;
            exe_d.imm             = head_ent.imm;
            exe_d.src0            = rf_rdata0_i;
            exe_d.src1            = rf_rdata1_i;
            exe_d.llbit           = head_ent.llbit;
        end else if (exe_ready_i) begin
            exe_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            head_q <= '0;
            tail_q <= '0;
            exe_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            exe_q  <= exe_d;
        end
    end

    assign exe_o = exe_q;

endmodule

// File: tb/tb_mem_issue_queue.sv
module tb_mem_issue_queue;
    import mem_issue_queue_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush_i;
    logic             dis_valid_i;
    logic             dis_ready_o;
    MemIqEntrySt      dis_i;
    logic [3:0]       wakeup_valid_i;
    logic [3:0][5:0]  wakeup_preg_i;
    logic [5:0]       rf_raddr0_o, rf_raddr1_o;
    logic [31:0]      rf_rdata0_i, rf_rdata1_i;
    MemExeSt          exe_o;
    logic             exe_ready_i;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // register file model: data is a tagged copy of the address
    assign rf_rdata0_i = 32'hA5A5_0000 | {26'd0, rf_raddr0_o};
    assign rf_rdata1_i = 32'h5A5A_0000 | {26'd0, rf_raddr1_o};

    mem_issue_queue #(
        .DEPTH        (8),
        .WAKEUP_PORTS (4),
        .PREG_W       (6)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .flush_i        (flush_i),
        .dis_valid_i    (dis_valid_i),
        .dis_ready_o    (dis_ready_o),
        .dis_i          (dis_i),
        .wakeup_valid_i (wakeup_valid_i),
        .wakeup_preg_i  (wakeup_preg_i),
        .rf_raddr0_o    (rf_raddr0_o),
        .rf_raddr1_o    (rf_raddr1_o),
        .rf_rdata0_i    (rf_rdata0_i),
        .rf_rdata1_i    (rf_rdata1_i),
        .exe_o          (exe_o),
        .exe_ready_i    (exe_ready_i)
    );

    function automatic MemIqEntrySt mk(input mem_oc_e oc, input logic [5:0] p0, input logic r0,
                                       input logic [5:0] p1, input logic r1, input logic [5:0] rob);
        MemIqEntrySt e;
        e             = '0;
        e.psrc0       = p0;
        e.psrc1       = p1;
        e.src0_ready  = r0;
        e.src1_ready  = r1;
        e.imm         = 32'h100 + {26'd0, rob};
        e.mem_oc      = oc;
        e.code        = 4'h3;
        e.pdest       = rob ^ 6'h20;
        e.pdest_valid = (oc == MEM_LOAD);
        e.rob_idx     = rob;
        e.llbit       = rob[0];
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        n_checks++; if (dis_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_dis_ready got %b exp 1", dis_ready_o); end
        n_checks++; if (exe_o !== '0) begin n_fail++; $display("FAIL reset_exe got %h exp 0", exe_o); end
        n_checks++; if (rf_raddr0_o !== 6'd0) begin n_fail++; $display("FAIL reset_raddr0 got %0d exp 0", rf_raddr0_o); end
        n_checks++; if (rf_raddr1_o !== 6'd0) begin n_fail++; $display("FAIL reset_raddr1 got %0d exp 0", rf_raddr1_o); end
    endtask

    task automatic test_basic();
        exe_ready_i = 1'b1;
        // psrc1=0 flagged not ready: register 0 must count as ready anyway
        dis_valid_i = 1'b1;
        dis_i = mk(MEM_LOAD, 6'd5, 1'b1, 6'd0, 1'b0, 6'd1);
        tick();
        dis_valid_i = 1'b0;
        n_checks++; if (exe_o.base.valid !== 1'b0) begin n_fail++; $display("FAIL basic_early got %b exp 0", exe_o.base.valid); end
        n_checks++; if (rf_raddr0_o !== 6'd5) begin n_fail++; $display("FAIL basic_raddr0 got %0d exp 5", rf_raddr0_o); end
        tick();
        n_checks++; if (exe_o.base.valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %b exp 1", exe_o.base.valid); end
        n_checks++; if (exe_o.src0 !== 32'hA5A5_0005) begin n_fail++; $display("FAIL basic_src0 got %h exp a5a50005", exe_o.src0); end
        n_checks++; if (exe_o.src1 !== 32'h5A5A_0000) begin n_fail++; $display("FAIL basic_src1 got %h exp 5a5a0000", exe_o.src1); end
        n_checks++; if (exe_o.base.rob_idx !== 6'd1) begin n_fail++; $display("FAIL basic_rob got %0d exp 1", exe_o.base.rob_idx); end
        n_checks++; if (exe_o.imm !== 32'h101) begin n_fail++; $display("FAIL basic_imm got %h exp 101", exe_o.imm); end
        n_checks++; if (exe_o.base.pdest !== 6'h21) begin n_fail++; $display("FAIL basic_pdest got %h exp 21", exe_o.base.pdest); end
        n_checks++; if (dis_ready_o !== 1'b1) begin n_fail++; $display("FAIL basic_dis_ready got %b exp 1", dis_ready_o); end
        tick();
        n_checks++; if (exe_o.base.valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain got %b exp 0", exe_o.base.valid); end
    endtask

    task automatic test_wakeup();
        exe_ready_i = 1'b1;
        dis_valid_i = 1'b1;
        dis_i = mk(MEM_STORE, 6'd0, 1'b1, 6'd12, 1'b0, 6'd2);
        tick();
        dis_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++; if (exe_o.base.valid !== 1'b0) begin n_fail++; $display("FAIL wakeup_wait%0d got %b exp 0", i, exe_o.base.valid); end
        end
        wakeup_valid_i = 4'b0100;
        wakeup_preg_i[2] = 6'd12;
        tick();
        wakeup_valid_i = '0;
        n_checks++; if (exe_o.base.valid !== 1'b0) begin n_fail++; $display("FAIL wakeup_at_edge got %b exp 0", exe_o.base.valid); end
        tick();
        n_checks++; if (exe_o.base.valid !== 1'b1) begin n_fail++; $display("FAIL wakeup_issue got %b exp 1", exe_o.base.valid); end
        n_checks++; if (exe_o.base.rob_idx !== 6'd2) begin n_fail++; $display("FAIL wakeup_rob got %0d exp 2", exe_o.base.rob_idx); end
        n_checks++; if (exe_o.src1 !== 32'h5A5A_000C) begin n_fail++; $display("FAIL wakeup_src1 got %h exp 5a5a000c", exe_o.src1); end
        n_checks++; if (exe_o.mem_oc !== MEM_STORE) begin n_fail++; $display("FAIL wakeup_oc got %0d exp 1", exe_o.mem_oc); end
        tick();
        n_checks++; if (exe_o.base.valid !== 1'b0) begin n_fail++; $display("FAIL wakeup_drain got %b exp 0", exe_o.base.valid); end
    endtask

    task automatic test_full_wrap();
        exe_ready_i = 1'b0;
        // op0 moves straight into the empty output register; ops 1..8 fill the queue
        for (int i = 0; i < 9; i++) begin
            n_checks++; if (dis_ready_o !== 1'b1) begin n_fail++; $display("FAIL fill_ready%0d got %b exp 1", i, dis_ready_o); end
            dis_valid_i = 1'b1;
            dis_i = mk(MEM_LOAD, 6'(i + 1), 1'b1, 6'd0, 1'b1, 6'(i));
            tick();
        end
        n_checks++; if (dis_ready_o !== 1'b0) begin n_fail++; $display("FAIL full_ready got %b exp 0", dis_ready_o); end
        dis_i = mk(MEM_LOAD, 6'd10, 1'b1, 6'd0, 1'b1, 6'd9);
        tick();
        dis_valid_i = 1'b0;
        n_checks++; if (dis_ready_o !== 1'b0) begin n_fail++; $display("FAIL full_hold got %b exp 0", dis_ready_o); end
        n_checks++; if (exe_o.base.rob_idx !== 6'd0 || exe_o.base.valid !== 1'b1) begin n_fail++; $display("FAIL full_exe got v%b rob%0d exp v1 rob0", exe_o.base.valid, exe_o.base.rob_idx); end
        exe_ready_i = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            n_checks++; if (exe_o.base.valid !== 1'b1 || exe_o.base.rob_idx !== 6'(k)) begin n_fail++; $display("FAIL drain_rob%0d got v%b rob%0d exp v1 rob%0d", k, exe_o.base.valid, exe_o.base.rob_idx, k); end
            n_checks++; if (exe_o.src0 !== (32'hA5A5_0000 | 32'(k + 1))) begin n_fail++; $display("FAIL drain_src0_%0d got %h exp %h", k, exe_o.src0, 32'hA5A5_0000 | 32'(k + 1)); end
            if (k == 1) begin
                n_checks++; if (dis_ready_o !== 1'b1) begin n_fail++; $display("FAIL drain_ready_rise got %b exp 1", dis_ready_o); end
            end
        end
        tick();
        n_checks++; if (exe_o.base.valid !== 1'b0) begin n_fail++; $display("FAIL drain_refused_dropped got %b exp 0", exe_o.base.valid); end
        // second batch crosses the pointer wrap at back-to-back rate
        for (int j = 0; j < 8; j++) begin
            dis_valid_i = 1'b1;
            dis_i = mk(MEM_LOAD, 6'(j + 20), 1'b1, 6'(j + 40), 1'b1, 6'(j + 16));
            tick();
            if (j == 0) begin
                n_checks++; if (exe_o.base.valid !== 1'b0) begin n_fail++; $display("FAIL wrap_first got %b exp 0", exe_o.base.valid); end
            end else begin
                n_checks++; if (exe_o.base.valid !== 1'b1 || exe_o.base.rob_idx !== 6'(j + 15)) begin n_fail++; $display("FAIL wrap_rob%0d got v%b rob%0d exp v1 rob%0d", j, exe_o.base.valid, exe_o.base.rob_idx, j + 15); end
            end
        end
        dis_valid_i = 1'b0;
        tick();
        n_checks++; if (exe_o.base.rob_idx !== 6'd23 || exe_o.src1 !== 32'h5A5A_002F) begin n_fail++; $display("FAIL wrap_last got rob%0d src1 %h exp rob23 src1 5a5a002f", exe_o.base.rob_idx, exe_o.src1); end
        tick();
        n_checks++; if (exe_o.base.valid !== 1'b0) begin n_fail++; $display("FAIL wrap_drain got %b exp 0", exe_o.base.valid); end
    endtask

    task automatic test_in_order_block();
        exe_ready_i = 1'b1;
        dis_valid_i = 1'b1;
        dis_i = mk(MEM_LOAD, 6'd9, 1'b0, 6'd0, 1'b1, 6'd30);
        tick();
        dis_i = mk(MEM_STORE, 6'd0, 1'b1, 6'd0, 1'b1, 6'd31);
        tick();
        dis_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            // unrelated broadcast must not wake the head
            wakeup_valid_i = 4'b0010;
            wakeup_preg_i[1] = 6'd10;
            tick();
            n_checks++; if (exe_o.base.valid !== 1'b0) begin n_fail++; $display("FAIL block_wait%0d got %b exp 0", i, exe_o.base.valid); end
        end
        wakeup_valid_i = 4'b0001;
        wakeup_preg_i[0] = 6'd9;
        tick();
        wakeup_valid_i = '0;
        n_checks++; if (exe_o.base.valid !== 1'b0) begin n_fail++; $display("FAIL block_at_edge got %b exp 0", exe_o.base.valid); end
        tick();
        n_checks++; if (exe_o.base.valid !== 1'b1 || exe_o.base.rob_idx !== 6'd30) begin n_fail++; $display("FAIL block_head got v%b rob%0d exp v1 rob30", exe_o.base.valid, exe_o.base.rob_idx); end
        tick();
        n_checks++; if (exe_o.base.valid !== 1'b1 || exe_o.base.rob_idx !== 6'd31) begin n_fail++; $display("FAIL block_next got v%b rob%0d exp v1 rob31", exe_o.base.valid, exe_o.base.rob_idx); end
        tick();
        n_checks++; if (exe_o.base.valid !== 1'b0) begin n_fail++; $display("FAIL block_drain got %b exp 0", exe_o.base.valid); end
    endtask

    task automatic test_flush();
        exe_ready_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            dis_valid_i = 1'b1;
            dis_i = mk(MEM_LOAD, 6'(i + 1), 1'b1, 6'(i + 2), 1'b1, 6'(40 + i));
            tick();
        end
        n_checks++; if (exe_o.base.valid !== 1'b1 || exe_o.base.rob_idx !== 6'd40) begin n_fail++; $display("FAIL flush_pre got v%b rob%0d exp v1 rob40", exe_o.base.valid, exe_o.base.rob_idx); end
        flush_i = 1'b1;
        dis_i = mk(MEM_LOAD, 6'd3, 1'b1, 6'd0, 1'b1, 6'd50);
        tick();
        flush_i = 1'b0;
        dis_valid_i = 1'b0;
        n_checks++; if (exe_o !== '0) begin n_fail++; $display("FAIL flush_exe got %h exp 0", exe_o); end
        n_checks++; if (dis_ready_o !== 1'b1) begin n_fail++; $display("FAIL flush_ready got %b exp 1", dis_ready_o); end
        n_checks++; if (rf_raddr0_o !== 6'd0) begin n_fail++; $display("FAIL flush_raddr0 got %0d exp 0", rf_raddr0_o); end
        exe_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (exe_o.base.valid !== 1'b0) begin n_fail++; $display("FAIL flush_empty%0d got %b exp 0", i, exe_o.base.valid); end
        end
        dis_valid_i = 1'b1;
        dis_i = mk(MEM_CACOP, 6'd4, 1'b1, 6'd0, 1'b1, 6'd51);
        tick();
        dis_valid_i = 1'b0;
        tick();
        n_checks++; if (exe_o.base.valid !== 1'b1 || exe_o.base.rob_idx !== 6'd51) begin n_fail++; $display("FAIL flush_after got v%b rob%0d exp v1 rob51", exe_o.base.valid, exe_o.base.rob_idx); end
        tick();
    endtask

    task automatic test_same_cycle_wakeup();
        exe_ready_i = 1'b1;
        dis_valid_i = 1'b1;
        dis_i = mk(MEM_LOAD, 6'd7, 1'b0, 6'd0, 1'b1, 6'd60);
        wakeup_valid_i = 4'b1000;
        wakeup_preg_i[3] = 6'd7;
        tick();
        dis_valid_i = 1'b0;
        wakeup_valid_i = '0;
        n_checks++; if (exe_o.base.valid !== 1'b0) begin n_fail++; $display("FAIL scw_early got %b exp 0", exe_o.base.valid); end
        tick();
        n_checks++; if (exe_o.base.valid !== 1'b1 || exe_o.base.rob_idx !== 6'd60) begin n_fail++; $display("FAIL scw_issue got v%b rob%0d exp v1 rob60", exe_o.base.valid, exe_o.base.rob_idx); end
        n_checks++; if (exe_o.src0 !== 32'hA5A5_0007) begin n_fail++; $display("FAIL scw_src0 got %h exp a5a50007", exe_o.src0); end
        tick();
    endtask

    initial begin
        rst            = 1'b1;
        flush_i        = 1'b0;
        dis_valid_i    = 1'b0;
        dis_i          = '0;
        wakeup_valid_i = '0;
        wakeup_preg_i  = '0;
        exe_ready_i    = 1'b0;
        test_reset();
        test_basic();
        test_wakeup();
        test_full_wrap();
        test_in_order_block();
        test_flush();
        test_same_cycle_wakeup();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
